data_memory_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters: port A (core load/store) and port B (DMA/debug).

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 31 +++
 rtl/data_memory_arbiter.sv | 178 +++++++++++++++++
 tb/tb_data_memory_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// ----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and defaults for the data memory arbiter.
//   dmem_arb_state_t : arbiter FSM states (IDLE, ACCESS, RESP)
//   dmem_port_t      : requester identity (PORT_A = core, PORT_B = DMA/debug)
//   MEM_BYTES_DEFAULT: default size of the legal byte-address window
// ----------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } dmem_arb_state_t;

  typedef enum logic {
    PORT_A,
    PORT_B
  } dmem_port_t;

  localparam int MEM_BYTES_DEFAULT = 1024;

endpackage

// File: rtl/rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
//   Two-way round-robin arbiter, purely combinational.
//   Ports:
//     a_req, b_req  in  request lines of port A / port B
//     last_grant    in  port that completed the most recent access
//     grant_valid   out at least one request present
//     grant_port    out winning port (PORT_A / PORT_B)
// ----------------------------------------------------------------------------
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_port
);

  always_comb begin
    grant_valid = a_req | b_req;
    grant_port  = PORT_A;
    if (a_req && b_req) begin
      // On a tie the port that was not served last wins.
      grant_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (b_req) begin
      grant_port = PORT_B;
    end
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// ----------------------------------------------------------------------------
// data_memory_arbiter
//   Shares one single-port data memory between port A (core load/store) and
//   port B (DMA/debug). One access in flight, round-robin on ties, each access
//   is range/alignment checked; faulting accesses never reach the memory.
//   Ports:
//     CLK, Reset                 clock (rising edge), async active-high reset
//     a_req/a_we/a_addr/a_wdata  port A command, held until a_ack
//     a_ack/a_err/a_rdata        port A response (one-cycle ack pulse)
//     b_*                        same set for port B
//     MemRead/MemWrite           registered memory strobes
//     Address/WriteData          registered memory address / write data
//     ReadData                   combinational memory read data
//     busy                       FSM not in IDLE
// ----------------------------------------------------------------------------
module data_memory_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] ReadData,
  output logic              busy
);

  dmem_arb_state_t r_state, w_next_state;
  dmem_port_t      r_last_grant;
  dmem_port_t      r_port;
  logic            r_we;

  logic              r_mem_read, r_mem_write;
  logic [ADDR_W-1:0] r_address;
  logic [DATA_W-1:0] r_write_data;
  logic              r_a_ack, r_a_err, r_b_ack, r_b_err;
  logic [DATA_W-1:0] r_a_rdata, r_b_rdata;

  logic              w_grant_valid;
  logic              w_grant_port;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_fault;

  rr_arbiter2 u_rr (
    .a_req       (a_req),
    .b_req       (b_req),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_port  (w_grant_port)
  );

  // Command of the winning port, only meaningful in IDLE.
  always_comb begin
    w_sel_we    = a_we;
    w_sel_addr  = a_addr;
    w_sel_wdata = a_wdata;
    if (w_grant_port == PORT_B) begin
      w_sel_we    = b_we;
      w_sel_addr  = b_addr;
      w_sel_wdata = b_wdata;
    end
  end

  // Misalignment and out-of-range collapse into a single error.
  assign w_fault = (w_sel_addr[1:0] != 2'b00) ||
                   (w_sel_addr >= ADDR_W'(MEM_BYTES));

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_grant_valid) w_next_state = w_fault ? RESP : ACCESS;
      ACCESS:  w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_last_grant <= PORT_B;
      r_port       <= PORT_A;
      r_we         <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_address    <= '0;
      r_write_data <= '0;
      r_a_ack      <= 1'b0;
      r_a_err      <= 1'b0;
      r_b_ack      <= 1'b0;
      r_b_err      <= 1'b0;
      r_a_rdata    <= '0;
      r_b_rdata    <= '0;
    end else begin
      // ack/err are single-cycle pulses.
      r_a_ack <= 1'b0;
      r_a_err <= 1'b0;
      r_b_ack <= 1'b0;
      r_b_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_port <= dmem_port_t'(w_grant_port);
            r_we   <= w_sel_we;
            if (!w_fault) begin
              r_address    <= w_sel_addr;
              r_write_data <= w_sel_wdata;
              r_mem_read   <= ~w_sel_we;
              r_mem_write  <= w_sel_we;
            end else if (w_grant_port == PORT_A) begin
              // Faults answer straight away, memory stays untouched.
              r_a_ack   <= 1'b1;
              r_a_err   <= 1'b1;
              r_a_rdata <= '0;
            end else begin
              r_b_ack   <= 1'b1;
              r_b_err   <= 1'b1;
              r_b_rdata <= '0;
            end
          end
        end
        ACCESS: begin
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          if (r_port == PORT_A) begin
            r_a_ack   <= 1'b1;
            r_a_rdata <= r_we ? '0 : ReadData;
          end else begin
            r_b_ack   <= 1'b1;
            r_b_rdata <= r_we ? '0 : ReadData;
          end
        end
        RESP: begin
          r_last_grant <= r_port;
        end
        default: ;
      endcase
    end
  end

  assign MemRead   = r_mem_read;
  assign MemWrite  = r_mem_write;
  assign Address   = r_address;
  assign WriteData = r_write_data;
  assign a_ack     = r_a_ack;
  assign a_err     = r_a_err;
  assign a_rdata   = r_a_rdata;
  assign b_ack     = r_b_ack;
  assign b_err     = r_b_err;
  assign b_rdata   = r_b_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_data_memory_arbiter.sv
module tb_data_memory_arbiter;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_err, b_ack, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        MemRead, MemWrite, busy;
  logic [31:0] Address, WriteData, ReadData;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] mem [256];

  data_memory_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(1024)) dut (
    .CLK(CLK), .Reset(Reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_err(b_err), .b_rdata(b_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address),
    .WriteData(WriteData), .ReadData(ReadData), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Behavioural single-port memory: combinational read, write at clock edge.
  assign ReadData = MemRead ? mem[Address[9:2]] : 32'hBAD0_BAD0;
  always @(posedge CLK) if (MemWrite) mem[Address[9:2]] <= WriteData;

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    if (!port) begin a_req = req; a_we = we; a_addr = addr; a_wdata = wdata; end
    else       begin b_req = req; b_we = we; b_addr = addr; b_wdata = wdata; end
  endtask

  // Drives one transaction from an IDLE cycle and reports what was observed.
  // lat is the number of clock edges from the request to the ack (-1: none).
  task automatic run_txn(input bit port, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err,
                         output int rd_cyc, output int wr_cyc,
                         output int other_ack, output logic [31:0] strobe_addr);
    lat = -1; rd_cyc = 0; wr_cyc = 0; other_ack = 0;
    rdata = 32'hxxxx_xxxx; err = 1'bx; strobe_addr = 32'h0;
    set_port(port, 1'b1, we, addr, wdata);
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      @(posedge CLK); #1;
      if (MemRead)  rd_cyc++;
      if (MemWrite) wr_cyc++;
      if (MemRead || MemWrite) strobe_addr = Address;
      if (port ? a_ack : b_ack) other_ack++;
      if (port ? b_ack : a_ack) begin
        lat   = c;
        rdata = port ? b_rdata : a_rdata;
        err   = port ? b_err : a_err;
        set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    set_port(port, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    set_port(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_port(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge CLK);
    #1;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", busy); end
    compared++; if ({MemRead, MemWrite} !== 2'b00) begin mismatched++; $display("FAIL reset_strobes: got %b want 00", {MemRead, MemWrite}); end
    compared++; if (Address !== 32'h0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", Address); end
    compared++; if (WriteData !== 32'h0) begin mismatched++; $display("FAIL reset_wdata: got %h want 0", WriteData); end
    compared++; if ({a_ack, a_err, b_ack, b_err} !== 4'b0) begin mismatched++; $display("FAIL reset_acks: got %b want 0000", {a_ack, a_err, b_ack, b_err}); end
    compared++; if ({a_rdata, b_rdata} !== 64'h0) begin mismatched++; $display("FAIL reset_rdata: got %h want 0", {a_rdata, b_rdata}); end
    Reset = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read();
    int lat, rdc, wrc, oth;
    logic [31:0] rd, sa;
    logic er;
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, lat, rd, er, rdc, wrc, oth, sa);
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL wr_latency: got %0d want 2", lat); end
    compared++; if (wrc !== 1 || rdc !== 0) begin mismatched++; $display("FAIL wr_strobes: got wr=%0d rd=%0d want wr=1 rd=0", wrc, rdc); end
    compared++; if (sa !== 32'h10) begin mismatched++; $display("FAIL wr_address: got %h want 00000010", sa); end
    compared++; if (er !== 1'b0 || rd !== 32'h0) begin mismatched++; $display("FAIL wr_resp: got err=%b rdata=%h want err=0 rdata=0", er, rd); end
    compared++; if (a_ack !== 1'b0) begin mismatched++; $display("FAIL wr_ack_pulse: got %b want 0", a_ack); end
    compared++; if (mem[4] !== 32'hDEAD_BEEF) begin mismatched++; $display("FAIL wr_commit: got %h want deadbeef", mem[4]); end
    run_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0, lat, rd, er, rdc, wrc, oth, sa);
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL rd_latency: got %0d want 2", lat); end
    compared++; if (rdc !== 1 || wrc !== 0) begin mismatched++; $display("FAIL rd_strobes: got rd=%0d wr=%0d want rd=1 wr=0", rdc, wrc); end
    compared++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin mismatched++; $display("FAIL rd_data: got %h err=%b want deadbeef err=0", rd, er); end
    compared++; if (oth !== 0) begin mismatched++; $display("FAIL rd_other_ack: got %0d want 0", oth); end
  endtask

  task automatic test_round_robin();
    int lat, rdc, wrc, oth;
    logic [31:0] rd, sa;
    logic er;
    int a_n, a_t1, a_t2, b_t;
    logic [31:0] a_r1, a_r2, b_r, a_hold;
    run_txn(1'b0, 1'b1, 32'h20, 32'h1111_AAAA, lat, rd, er, rdc, wrc, oth, sa);
    run_txn(1'b0, 1'b1, 32'h24, 32'h2222_BBBB, lat, rd, er, rdc, wrc, oth, sa);
    run_txn(1'b0, 1'b1, 32'h28, 32'h3333_CCCC, lat, rd, er, rdc, wrc, oth, sa);
    Reset = 1'b1; #2; Reset = 1'b0;
    @(posedge CLK); #1;
    a_n = 0; a_t1 = 0; a_t2 = 0; b_t = 0;
    a_r1 = 0; a_r2 = 0; b_r = 0; a_hold = 0;
    set_port(1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    set_port(1'b1, 1'b1, 1'b0, 32'h24, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      @(posedge CLK); #1;
      if (a_ack) begin
        if (a_n == 0) begin
          // A immediately issues a new command, so both contend again.
          a_t1 = c; a_r1 = a_rdata; a_addr = 32'h28; a_n = 1;
        end else begin
          a_t2 = c; a_r2 = a_rdata; a_req = 1'b0; a_n = 2;
        end
      end
      if (b_ack) begin
        b_t = c; b_r = b_rdata; a_hold = a_rdata; b_req = 1'b0;
      end
    end
    compared++; if (a_t1 !== 2) begin mismatched++; $display("FAIL rr_first_a: got ack at %0d want 2", a_t1); end
    compared++; if (b_t !== 5) begin mismatched++; $display("FAIL rr_then_b: got ack at %0d want 5", b_t); end
    compared++; if (a_t2 !== 8) begin mismatched++; $display("FAIL rr_then_a: got ack at %0d want 8", a_t2); end
    compared++; if (a_r1 !== 32'h1111_AAAA || b_r !== 32'h2222_BBBB || a_r2 !== 32'h3333_CCCC) begin mismatched++; $display("FAIL rr_data: got %h %h %h want 1111aaaa 2222bbbb 3333cccc", a_r1, b_r, a_r2); end
    compared++; if (a_hold !== 32'h1111_AAAA) begin mismatched++; $display("FAIL rr_rdata_hold: got %h want 1111aaaa", a_hold); end
  endtask

  task automatic test_faults();
    int lat, rdc, wrc, oth;
    logic [31:0] rd, sa;
    logic er;
    logic [31:0] addrs [3];
    bit          wes   [3];
    addrs[0] = 32'h0000_0006; wes[0] = 1'b0;
    addrs[1] = 32'h0000_0400; wes[1] = 1'b0;
    addrs[2] = 32'h0000_0402; wes[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b1, wes[i], addrs[i], 32'h5555_5555, lat, rd, er, rdc, wrc, oth, sa);
      compared++; if (lat !== 1) begin mismatched++; $display("FAIL fault_latency[%0d]: got %0d want 1", i, lat); end
      compared++; if (er !== 1'b1 || rd !== 32'h0) begin mismatched++; $display("FAIL fault_resp[%0d]: got err=%b rdata=%h want err=1 rdata=0", i, er, rd); end
      compared++; if (rdc !== 0 || wrc !== 0) begin mismatched++; $display("FAIL fault_strobes[%0d]: got rd=%0d wr=%0d want 0 0", i, rdc, wrc); end
      compared++; if (oth !== 0) begin mismatched++; $display("FAIL fault_other_ack[%0d]: got %0d want 0", i, oth); end
    end
  endtask

  task automatic test_back_to_back();
    int a_cnt, a_t, b_t;
    logic [31:0] b_r;
    a_cnt = 0; a_t = 0; b_t = 0; b_r = 0;
    set_port(1'b0, 1'b1, 1'b1, 32'h30, 32'h1234_5678);
    for (int c = 1; c <= 10; c++) begin
      @(posedge CLK); #1;
      if (c == 1) set_port(1'b1, 1'b1, 1'b0, 32'h30, 32'h0);
      if (a_ack) begin a_cnt++; a_t = c; a_req = 1'b0; end
      if (b_ack) begin b_t = c; b_r = b_rdata; b_req = 1'b0; end
    end
    compared++; if (a_cnt !== 1 || a_t !== 2) begin mismatched++; $display("FAIL b2b_a_ack: got count=%0d at=%0d want 1 at 2", a_cnt, a_t); end
    compared++; if (b_t - a_t !== 3) begin mismatched++; $display("FAIL b2b_gap: got %0d want 3", b_t - a_t); end
    compared++; if (b_r !== 32'h1234_5678) begin mismatched++; $display("FAIL b2b_b_data: got %h want 12345678", b_r); end
  endtask

  task automatic test_reset_mid_access();
    int lat, rdc, wrc, oth, acks;
    logic [31:0] rd, sa;
    logic er;
    set_port(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge CLK); #1;
    compared++; if (MemRead !== 1'b1) begin mismatched++; $display("FAIL rst_mid_strobe_before: got %b want 1", MemRead); end
    #2 Reset = 1'b1;
    #1;
    compared++; if (MemRead !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid_async: got MemRead=%b busy=%b want 0 0", MemRead, busy); end
    a_req = 1'b0;
    #1 Reset = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (a_ack || b_ack) acks++;
    end
    compared++; if (acks !== 0) begin mismatched++; $display("FAIL rst_mid_no_ack: got %0d want 0", acks); end
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, lat, rd, er, rdc, wrc, oth, sa);
    compared++; if (lat !== 2 || rd !== 32'hDEAD_BEEF || er !== 1'b0) begin mismatched++; $display("FAIL rst_mid_recover: got lat=%0d rdata=%h err=%b want 2 deadbeef 0", lat, rd, er); end
  endtask

  task automatic test_req_drop();
    int lat, rdc, wrc, oth, acks, wrs;
    logic [31:0] rd, sa;
    logic er;
    acks = 0; wrs = 0;
    set_port(1'b0, 1'b1, 1'b1, 32'h40, 32'hCAFE_F00D);
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (c == 1) a_req = 1'b0;
      if (a_ack) acks++;
      if (MemWrite) wrs++;
    end
    compared++; if (acks !== 1) begin mismatched++; $display("FAIL drop_ack_count: got %0d want 1", acks); end
    compared++; if (wrs !== 1) begin mismatched++; $display("FAIL drop_single_access: got %0d want 1", wrs); end
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL drop_idle: got busy=%b want 0", busy); end
    run_txn(1'b0, 1'b0, 32'h40, 32'h0, lat, rd, er, rdc, wrc, oth, sa);
    compared++; if (rd !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL drop_readback: got %h want cafef00d", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_faults();
    test_back_to_back();
    test_reset_mid_access();
    test_req_drop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
